// File: rtl/burst_acc_pkg.sv
// rtl/burst_acc_pkg.sv - shared constants and state encoding for burst_accumulator
package burst_acc_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_BURST = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/burst_accumulator_rca.sv
// rtl/burst_accumulator_rca.sv - combinational ripple-carry adder used as the accumulator datapath
module burst_accumulator_rca #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cy_in,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cy_out
);

    logic [WIDTH:0] w_carry;

    assign w_carry[0] = i_cy_in;

    // one full-adder cell per bit, carry rippling from LSB to MSB
    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        assign o_sum[g]       = i_a[g] ^ i_b[g] ^ w_carry[g];
        assign w_carry[g + 1] = (i_a[g] & i_b[g]) | (w_carry[g] & (i_a[g] ^ i_b[g]));
    end

    assign o_cy_out = w_carry[WIDTH];

endmodule

// File: rtl/burst_accumulator.sv
// rtl/burst_accumulator.sv - accumulates a burst of operands through the ripple adder; optional BURST_ACC_SATURATE_EN clamps on overflow
module burst_accumulator
    import burst_acc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int BURST = DEF_BURST
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ovf,
    output logic             busy
);

    localparam int CNT_W = $clog2(BURST + 1);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [WIDTH-1:0] r_acc;
    logic             r_ovf;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_sum;
    logic             w_cy_out;
    logic             w_handshake;
    logic             w_last;

    burst_accumulator_rca #(
        .WIDTH(WIDTH)
    ) u_rca (
        .i_a      (r_acc),
        .i_b      (in_data),
        .i_cy_in  (in_cin),
        .o_sum    (w_sum),
        .o_cy_out (w_cy_out)
    );

    assign w_handshake = in_valid & in_ready;
    assign w_last      = w_handshake && (r_cnt == CNT_W'(BURST - 1));

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // next-state decode; start is only honoured in IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (start)     w_next_state = ST_ACCUM;
            ST_ACCUM: if (w_last)    w_next_state = ST_DONE;
            ST_DONE:  if (out_ready) w_next_state = ST_IDLE;
            default:                 w_next_state = ST_IDLE;
        endcase
    end

    // outputs decoded from the registered state; result is zero outside DONE
    always_comb begin
        in_ready  = (r_state == ST_ACCUM);
        out_valid = (r_state == ST_DONE);
        busy      = (r_state == ST_ACCUM) || (r_state == ST_DONE);
        out_sum   = (r_state == ST_DONE) ? r_acc : '0;
        out_ovf   = (r_state == ST_DONE) && r_ovf;
    end

    // accumulator, sticky overflow and operand counter; cleared on start, updated per handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
            r_cnt <= '0;
        end else if (r_state == ST_IDLE && start) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
            r_cnt <= '0;
        end else if (r_state == ST_ACCUM && w_handshake) begin
`ifdef BURST_ACC_SATURATE_EN
            if (w_cy_out || (r_acc == {WIDTH{1'b1}})) begin
                r_acc <= {WIDTH{1'b1}};
            end else begin
                r_acc <= w_sum;
            end
`else
            r_acc <= w_sum;
`endif
            r_ovf <= r_ovf | w_cy_out;
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_burst_accumulator.sv
// tb/tb_burst_accumulator.sv - randomized self-checking bench for burst_accumulator against a burst-level sum model
module tb_burst_accumulator;

    localparam int W = 4;
    localparam int B = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         in_cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_sum;
    logic         out_ovf;
    logic         busy;

    int total = 0;
    int bad = 0;

    logic [W-1:0] q_data[$];
    logic         q_cin[$];

    burst_accumulator #(
        .WIDTH(W),
        .BURST(B)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_sum"}, out_sum, 0);
        check({tag, "_out_ovf"}, out_ovf, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // pulse start from IDLE; returns at posedge+1 with the DUT in ACCUM
    task automatic begin_burst();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // offer one operand after gap idle cycles; returns at posedge+1 just after the handshake edge
    task automatic send_op(input logic [W-1:0] d, input logic c, input int gap, input string tag);
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_data  = W'($urandom);
            in_cin   = 1'($urandom);
            @(negedge clk);
            check({tag, "_gap_ready"}, in_ready, 1);
            check({tag, "_gap_no_valid"}, out_valid, 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_cin   = c;
        @(negedge clk);
        check({tag, "_hs_ready"}, in_ready, 1);
        check({tag, "_hs_busy"}, busy, 1);
        check({tag, "_hs_no_valid"}, out_valid, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // full burst over q_data/q_cin; gap<0 picks random gaps of 0..2 cycles
    task automatic run_burst(input string tag, input int gap, input int bp, input bit poke_start);
        logic [W:0]   t;
        logic [W-1:0] exp_sum;
        logic         exp_ovf;
        logic [W-1:0] held;
        exp_sum = '0;
        exp_ovf = 1'b0;
        foreach (q_data[i]) begin
            t = {1'b0, exp_sum} + {1'b0, q_data[i]} + (W+1)'(q_cin[i]);
            if (t[W]) exp_ovf = 1'b1;
`ifdef BURST_ACC_SATURATE_EN
            if (t[W] || exp_sum == {W{1'b1}}) exp_sum = {W{1'b1}};
            else exp_sum = t[W-1:0];
`else
            exp_sum = t[W-1:0];
`endif
        end
        begin_burst();
        foreach (q_data[i]) begin
            send_op(q_data[i], q_cin[i], (gap < 0) ? int'($urandom_range(0, 2)) : gap, tag);
        end
        if (bp == 0) out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_latency_valid"}, out_valid, 1);
        check({tag, "_sum"}, out_sum, exp_sum);
        check({tag, "_ovf"}, out_ovf, exp_ovf);
        check({tag, "_done_ready"}, in_ready, 0);
        held = out_sum;
        if (bp > 0) begin
            @(posedge clk); #1;
            for (int k = 1; k < bp; k++) begin
                start    = poke_start;
                in_valid = 1'($urandom);
                in_data  = W'($urandom);
                @(negedge clk);
                check({tag, "_bp_valid"}, out_valid, 1);
                check({tag, "_bp_sum_stable"}, out_sum, held);
                check({tag, "_bp_ovf"}, out_ovf, exp_ovf);
                check({tag, "_bp_ready"}, in_ready, 0);
                check({tag, "_bp_busy"}, busy, 1);
                @(posedge clk); #1;
            end
            out_ready = 1'b1;
            start     = poke_start;
            in_valid  = 1'b0;
            @(negedge clk);
            check({tag, "_bp_final_valid"}, out_valid, 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        start     = 1'b0;
        @(negedge clk);
        check_idle({tag, "_after"});
    endtask

    initial begin
        // reset held with random input activity
        for (int i = 0; i < 3; i++) begin
            start     = 1'($urandom);
            in_valid  = 1'($urandom);
            in_data   = W'($urandom);
            in_cin    = 1'($urandom);
            out_ready = 1'($urandom);
            @(negedge clk);
            check_idle("reset");
        end
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("post_reset");

        q_data = '{4'd1, 4'd2, 4'd3, 4'd4};  q_cin = '{0, 0, 0, 0};
        run_burst("basic", 0, 0, 0);

        q_data = '{4'd15, 4'd1, 4'd0, 4'd0}; q_cin = '{0, 0, 0, 0};
        run_burst("overflow", 0, 0, 0);

        q_data = '{4'd5, 4'd3, 4'd0, 4'd0};  q_cin = '{1, 1, 1, 1};
        run_burst("cin_gaps", 2, 0, 0);

        q_data = '{4'd9, 4'd4, 4'd2, 4'd6};  q_cin = '{0, 1, 0, 1};
        run_burst("backpressure", 0, 4, 1);

        // reset mid-burst after two of four handshakes
        begin_burst();
        send_op(4'd7, 1'b0, 0, "midrst");
        send_op(4'd7, 1'b0, 0, "midrst");
        rst_n = 1'b0;
        #1;
        check_idle("midrst_async");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("midrst_release");
        q_data = '{4'd1, 4'd1, 4'd1, 4'd1}; q_cin = '{0, 0, 0, 0};
        run_burst("after_midrst", 0, 0, 0);

        for (int n = 0; n < 25; n++) begin
            q_data.delete();
            q_cin.delete();
            for (int i = 0; i < B; i++) begin
                q_data.push_back(W'($urandom));
                q_cin.push_back(1'($urandom));
            end
            run_burst("random", -1, int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
